counter_rmw_engine: RTL and testbench

//  Read-modify-write front end for one SDPUltraRam probability table. Takes (addr, bit) requests on a valid/ready

---
 rtl/paqfe_pkg.sv | 15 +
 rtl/SDPUltraRam.sv | 20 ++
 rtl/counter_rmw_engine.sv | 76 +++++++
 tb/tb_counter_rmw_engine.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/paqfe_pkg.sv
// paqfe_pkg: shared probability defaults, FSM state type and the adaptive update rule
package paqfe_pkg;
    localparam int PROB_WIDTH = 12;
    localparam int PROB_RATE  = 4;
    localparam int PROB_INIT  = 2048;

    typedef enum logic {INIT, RUN} rmw_state_t;

    // Moves p toward 2^width (b=1) or toward 0 (b=0) by 1/2^rate of the gap
    function automatic logic [31:0] prob_update(input logic [31:0] p, input logic b, input int width, input int rate);
        logic [31:0] one;
        one = 32'd1 << width;
        return b ? p + ((one - p) >> rate) : p - (p >> rate);
    endfunction
endpackage

// File: rtl/SDPUltraRam.sv
// SDPUltraRam: simple dual-port RAM, read-before-write, output held while enb is low
module SDPUltraRam #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] dob
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (wea) mem[addra] <= dina;
        if (enb) dob <= mem[addrb];
    end
endmodule

// File: rtl/counter_rmw_engine.sv
// counter_rmw_engine: read-modify-write front end for one probability table.
// Initialises the table, then returns pre-update probabilities and writes back adapted values.
module counter_rmw_engine
    import paqfe_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = PROB_WIDTH,
    parameter int RATE       = PROB_RATE,
    parameter int INIT_VALUE = PROB_INIT
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  init_done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_p,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob
);
    rmw_state_t state, state_next;
    logic [ADDR_WIDTH-1:0] cnt, s1_addr;
    logic [DATA_WIDTH-1:0] fwd_data, upd;
    logic s1_valid, s1_bit, s1_fwd, accept, fire;

    assign in_ready  = state == RUN && (!s1_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign fire      = s1_valid && out_ready;
    assign out_valid = s1_valid;
    assign out_p     = s1_fwd ? fwd_data : ram_dob;
    assign upd       = DATA_WIDTH'(prob_update(32'(out_p), s1_bit, DATA_WIDTH, RATE));
    assign ram_enb   = accept;
    assign ram_addrb = in_addr;

    // Sweep writes are gated by reset so the write port stays quiet while held in reset
    always_comb begin
        state_next = (state == INIT && &cnt) ? RUN : state;
        ram_wea    = (state == INIT) ? reset : fire;
        ram_addra  = (state == INIT) ? cnt : s1_addr;
        ram_dina   = (state == INIT) ? DATA_WIDTH'(INIT_VALUE) : upd;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_bit    <= 1'b0;
            s1_fwd    <= 1'b0;
            fwd_data  <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) cnt <= cnt + ADDR_WIDTH'(1);
            if (state == INIT && &cnt) init_done <= 1'b1;
            // A read issued alongside a same-address write sees stale RAM data, so keep the new value aside
            if (accept) begin
                s1_valid <= 1'b1;
                s1_addr  <= in_addr;
                s1_bit   <= in_bit;
                s1_fwd   <= fire && in_addr == s1_addr;
                fwd_data <= upd;
            end else if (fire) begin
                s1_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_counter_rmw_engine.sv
// tb_counter_rmw_engine: directed and random requests checked against an in-order table model
module tb_counter_rmw_engine;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic init_done, in_valid, in_ready, in_bit, out_valid, out_ready;
    logic ram_wea, ram_enb;
    logic [3:0] in_addr, ram_addra, ram_addrb;
    logic [11:0] out_p, ram_dina, ram_dob;

    typedef struct {int p; int a; int n;} exp_t;
    exp_t q[$];
    int model [16];
    int checks = 0;
    int errors = 0;
    int last_p, last_n, prev_p;
    bit fired;

    always #5 clock = ~clock;

    counter_rmw_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(12), .RATE(4), .INIT_VALUE(2048)) dut (
        .clock(clock), .reset(reset), .init_done(init_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_bit(in_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
    );

    SDPUltraRam #(.ADDR_WIDTH(4), .DATA_WIDTH(12)) ram (
        .clock(clock), .wea(ram_wea), .addra(ram_addra), .dina(ram_dina),
        .enb(ram_enb), .addrb(ram_addrb), .dob(ram_dob)
    );

    function automatic int upd(input int p, input bit b);
        return b ? p + (4096 - p) / 16 : p - p / 16;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, then check outputs against the outstanding-request queue
    task automatic tick(input bit v, input int a, input bit b, input bit r);
        exp_t e;
        int p, n;
        bit busy;
        @(negedge clock);
        in_valid = v;
        in_addr = 4'(a);
        in_bit = b;
        out_ready = r;
        #1;
        busy = q.size() != 0;
        fired = 0;
        check("in_ready", in_ready, !busy || r);
        check("out_valid", out_valid, busy);
        check("ram_enb", ram_enb, v && (!busy || r));
        if (busy) begin
            e = q[0];
            check("out_p", out_p, e.p);
            check("ram_wea", ram_wea, r);
            if (r) begin
                check("ram_addra", ram_addra, e.a);
                check("ram_dina", ram_dina, e.n);
                void'(q.pop_front());
                last_p = int'(out_p);
                last_n = int'(ram_dina);
                fired = 1;
            end
        end else begin
            check("ram_wea_idle", ram_wea, 0);
        end
        if (v && (!busy || r)) begin
            p = model[a];
            n = upd(p, b);
            model[a] = n;
            q.push_back('{p: p, a: a, n: n});
            check("ram_addrb", ram_addrb, a);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid = 0;
        in_addr = 0;
        in_bit = 0;
        out_ready = 0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_wea", ram_wea, 0);
        check("rst_enb", ram_enb, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_init_done", init_done, 0);
        @(negedge clock);
        reset = 1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("sweep1_addra", ram_addra, i);
            check("sweep1_wea", ram_wea, 1);
            @(negedge clock);
        end
        #1;
        check("sweep1_addr7", ram_addra, 7);
        reset = 0;
        #1;
        check("midrst_wea", ram_wea, 0);
        check("midrst_init_done", init_done, 0);
        check("midrst_addra", ram_addra, 0);
        @(negedge clock);
        reset = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("sweep_addra", ram_addra, i);
            check("sweep_wea", ram_wea, 1);
            check("sweep_dina", ram_dina, 2048);
            check("sweep_in_ready", in_ready, 0);
            check("sweep_init_done", init_done, 0);
            @(negedge clock);
        end
        #1;
        check("init_done", init_done, 1);
        check("run_wea", ram_wea, 0);
        check("run_in_ready", in_ready, 1);
        for (int i = 0; i < 16; i++) model[i] = 2048;

        tick(1, 3, 1, 1);
        tick(0, 0, 0, 1);
        check("a3_first_p", last_p, 2048);
        check("a3_first_w", last_n, 2176);
        tick(1, 3, 1, 1);
        tick(0, 0, 0, 1);
        check("a3_second_p", last_p, 2176);
        check("a3_second_w", last_n, 2296);

        repeat (3) tick(1, 5, 0, 1);
        tick(0, 0, 0, 1);
        check("a5_third_p", last_p, 1800);
        check("a5_third_w", last_n, 1688);

        for (int i = 0; i < 10; i++) tick(1, (i % 2) ? 2 : 1, 1, 1);
        tick(0, 0, 0, 1);

        tick(1, 4, 1, 1);
        repeat (5) tick(1, 4, 1, 0);
        tick(1, 4, 1, 1);
        tick(1, 4, 0, 1);
        tick(1, 6, 1, 1);
        tick(0, 0, 0, 1);

        prev_p = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1, 9, 1, 1);
            if (fired) begin
                check("sat_up_mono", last_p >= prev_p, 1);
                check("sat_up_write", last_n >= last_p, 1);
                prev_p = last_p;
            end
        end
        tick(0, 0, 0, 1);
        prev_p = 4095;
        for (int i = 0; i < 200; i++) begin
            tick(1, 9, 0, 1);
            if (fired) begin
                check("sat_dn_mono", last_p <= prev_p, 1);
                check("sat_dn_write", last_n <= last_p, 1);
                prev_p = last_p;
            end
        end
        tick(0, 0, 0, 1);

        for (int i = 0; i < 400; i++)
            tick(($urandom % 4) != 0, $urandom_range(0, 15), $urandom % 2, ($urandom % 3) != 0);
        repeat (2) tick(0, 0, 0, 1);
        check("drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
